// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin arbiter sharing one pipelined full-precision adder among N_REQ requesters
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid [N_REQ]  per-requester request valid
//   req_ready [N_REQ]  one-hot grant (combinational)
//   req_a, req_b       packed operands, requester i at [i*DATA_BITS +: DATA_BITS]
//   rsp_valid [N_REQ]  one-hot response strobe
//   rsp_sum            DATA_BITS+1 bit exact sum for the flagged requester
//   busy               any request outstanding
module adder_scheduler #(
   parameter int N_REQ     = 4,
   parameter int DATA_BITS = 8,
   parameter int DTYPE     = 1,
   parameter int LATENCY   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ*DATA_BITS-1:0]   req_a,
   input  logic [N_REQ*DATA_BITS-1:0]   req_b,
   output logic [N_REQ-1:0]             rsp_valid,
   output logic [DATA_BITS:0]           rsp_sum,
   output logic                         busy
);
   localparam int SUM_BITS = DATA_BITS + 1;
   localparam int PW = $clog2(N_REQ);
   localparam logic SGN = (DTYPE == 1);
   logic [PW-1:0] ptr, gidx, nptr;
   logic [N_REQ-1:0] outstanding, eligible, hi, cand;
   logic [DATA_BITS-1:0] sel_a, sel_b;
   logic [SUM_BITS-1:0] sum;
   logic st_v [LATENCY];
   logic [N_REQ-1:0] st_tag [LATENCY];
   logic [SUM_BITS-1:0] st_sum [LATENCY];
   assign eligible = req_valid & ~outstanding;
   // indices at or above ptr win first; if none, wrap to the lowest eligible
   assign hi = eligible & ~((N_REQ'(1) << ptr) - N_REQ'(1));
   assign cand = (|hi) ? hi : eligible;
   // isolate lowest set bit of the candidate set
   assign req_ready = rst ? '0 : cand & (~cand + N_REQ'(1));
   always_comb begin
      gidx = '0;
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++)
         if (req_ready[i]) begin
            gidx = PW'(i);
            sel_a = req_a[i*DATA_BITS +: DATA_BITS];
            sel_b = req_b[i*DATA_BITS +: DATA_BITS];
         end
   end
   assign nptr = (gidx == PW'(N_REQ-1)) ? '0 : gidx + PW'(1);
   assign sum = {SGN & sel_a[DATA_BITS-1], sel_a} + {SGN & sel_b[DATA_BITS-1], sel_b};
   assign rsp_valid = st_tag[LATENCY-1] & {N_REQ{st_v[LATENCY-1]}};
   assign rsp_sum = st_sum[LATENCY-1];
   assign busy = |outstanding;
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         outstanding <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            st_v[s] <= 1'b0;
            st_tag[s] <= '0;
            st_sum[s] <= '0;
         end
      end else begin
         if (|req_ready) ptr <= nptr;
         outstanding <= (outstanding & ~rsp_valid) | req_ready;
         st_v[0] <= |req_ready;
         st_tag[0] <= req_ready;
         st_sum[0] <= sum;
         for (int s = 1; s < LATENCY; s++) begin
            st_v[s] <= st_v[s-1];
            st_tag[s] <= st_tag[s-1];
            st_sum[s] <= st_sum[s-1];
         end
      end
   end
endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler: randomized and directed check of adder_scheduler (signed and unsigned instances) against a cycle-level reference model
module tb_adder_scheduler;
   localparam int N = 4;
   localparam int W = 8;
   localparam int L = 2;
   localparam int S = W + 1;
   localparam int MAXC = 4096;
   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] req_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [N-1:0] rdy_s, rv_s, rdy_u, rv_u;
   logic [S-1:0] sum_s, sum_u;
   logic busy_s, busy_u;
   always #5 clk = ~clk;
   adder_scheduler #(.N_REQ(N), .DATA_BITS(W), .DTYPE(1), .LATENCY(L)) u_s (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_s),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rv_s), .rsp_sum(sum_s), .busy(busy_s));
   adder_scheduler #(.N_REQ(N), .DATA_BITS(W), .DTYPE(0), .LATENCY(L)) u_u (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_u),
      .req_a(req_a), .req_b(req_b), .rsp_valid(rv_u), .rsp_sum(sum_u), .busy(busy_u));
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int ptr = 0;
   int free_at [N];
   logic exp_v [MAXC];
   int exp_i [MAXC];
   logic [S-1:0] exp_ss [MAXC];
   logic [S-1:0] exp_su [MAXC];
   logic pend [N];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask
   // one clock cycle: inputs already applied; check outputs mid-cycle, then advance the model at the edge
   task automatic step(input logic r, output int g);
      logic [N-1:0] ev, er;
      logic bz;
      rst = r;
      @(negedge clk);
      g = -1;
      if (!r)
         for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (g < 0 && req_valid[i] && cyc >= free_at[i]) g = i;
         end
      er = (g >= 0) ? N'(1) << g : '0;
      ev = exp_v[cyc] ? N'(1) << exp_i[cyc] : '0;
      bz = 1'b0;
      for (int i = 0; i < N; i++) if (cyc < free_at[i]) bz = 1'b1;
      check("ready_s", 32'(rdy_s), 32'(er));
      check("ready_u", 32'(rdy_u), 32'(er));
      check("rsp_valid_s", 32'(rv_s), 32'(ev));
      check("rsp_valid_u", 32'(rv_u), 32'(ev));
      check("busy_s", 32'(busy_s), 32'(bz));
      check("busy_u", 32'(busy_u), 32'(bz));
      if (exp_v[cyc]) begin
         check("sum_signed", 32'(sum_s), 32'(exp_ss[cyc]));
         check("sum_unsigned", 32'(sum_u), 32'(exp_su[cyc]));
      end
      @(posedge clk);
      if (r) begin
         ptr = 0;
         for (int i = 0; i < N; i++) free_at[i] = 0;
         for (int c = cyc + 1; c <= cyc + L && c < MAXC; c++) exp_v[c] = 1'b0;
      end else if (g >= 0 && cyc + L < MAXC) begin
         logic [W-1:0] a, b;
         int sa, sb;
         a = req_a[g*W +: W];
         b = req_b[g*W +: W];
         sa = int'($signed(a));
         sb = int'($signed(b));
         free_at[g] = cyc + L + 1;
         exp_v[cyc+L] = 1'b1;
         exp_i[cyc+L] = g;
         exp_ss[cyc+L] = S'(sa + sb);
         exp_su[cyc+L] = S'(int'(a) + int'(b));
         ptr = (g + 1) % N;
      end
      cyc++;
      #1;
   endtask
   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i] = 1'b1;
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask
   task automatic idle(input int n);
      int g;
      req_valid = '0;
      for (int k = 0; k < n; k++) step(1'b0, g);
   endtask
   function automatic logic [W-1:0] rnd();
      logic [W-1:0] t;
      case ($urandom_range(0, 7))
         0: t = '0;
         1: t = 8'h7F;
         2: t = 8'h80;
         3: t = 8'hFF;
         default: t = W'($urandom);
      endcase
      return t;
   endfunction
   initial begin
      int g;
      for (int c = 0; c < MAXC; c++) exp_v[c] = 1'b0;
      for (int i = 0; i < N; i++) begin
         free_at[i] = 0;
         pend[i] = 1'b0;
      end
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rst = 1'b1;
      #1;
      step(1'b1, g);
      step(1'b1, g);
      check("reset_sum_s", 32'(sum_s), 32'd0);
      check("reset_sum_u", 32'(sum_u), 32'd0);
      // single request with positive overflow into the extra bit
      req_valid = '0;
      set_req(2, 8'h7F, 8'h01);
      step(1'b0, g);
      idle(4);
      // sign handling: most negative plus most negative, and all-ones
      set_req(0, 8'h80, 8'h80);
      step(1'b0, g);
      req_valid = '0;
      set_req(0, 8'hFF, 8'hFF);
      idle(3);
      set_req(0, 8'hFF, 8'hFF);
      step(1'b0, g);
      idle(4);
      // full contention from reset release
      step(1'b1, g);
      for (int i = 0; i < N; i++) set_req(i, W'(8'h11 * (i + 1)), W'(8'hF0 - 8'h21 * i));
      for (int k = 0; k < 8; k++) step(1'b0, g);
      idle(4);
      // single hog
      req_valid = '0;
      set_req(1, 8'h40, 8'hC3);
      for (int k = 0; k < 10; k++) step(1'b0, g);
      idle(4);
      // rotation: ptr moves to 2 after granting req 1, then 3 beats 0
      step(1'b1, g);
      req_valid = '0;
      set_req(1, 8'h05, 8'h06);
      step(1'b0, g);
      req_valid = '0;
      set_req(0, 8'h9A, 8'h33);
      set_req(3, 8'h21, 8'hE4);
      step(1'b0, g);
      step(1'b0, g);
      idle(4);
      // reset mid-flight
      req_valid = '0;
      set_req(0, 8'h12, 8'h34);
      step(1'b0, g);
      req_valid = '0;
      step(1'b1, g);
      set_req(0, 8'hC0, 8'hB0);
      step(1'b0, g);
      idle(4);
      // randomized traffic with occasional reset; pending requests keep their operands
      for (int n = 0; n < 2500; n++) begin
         logic r;
         r = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < N; i++)
            if (pend[i]) begin
               if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
            end else begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_a[i*W +: W] = rnd();
               req_b[i*W +: W] = rnd();
            end
         step(r, g);
         for (int i = 0; i < N; i++) pend[i] = req_valid[i] && !r && g != i;
      end
      idle(L + 2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Round-robin scheduler that shares one pipelined fixed-point adder among N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request per cycle, pushes it through an internal LATENCY-stage full-precision adder, and returns the sum tagged by a one-hot response vector. It sits between the per-channel datapath units and the single shared add resource.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_BITS, 8, operand width; both operands share the same binary point, so no alignment is done
- DTYPE, 1, operand type: 0 = unsigned, 1 = 2's complement
- LATENCY, 2, register stages from accepted request to response (1..4)
- SUM_BITS (local), DATA_BITS+1, full-precision result width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  one-hot grant; at most one bit high per cycle
- req_a  in  N_REQ*DATA_BITS  operand A; requester i occupies bits [i*DATA_BITS +: DATA_BITS]
- req_b  in  N_REQ*DATA_BITS  operand B; same packing as req_a
- rsp_valid  out  N_REQ  one-hot response strobe, one cycle wide
- rsp_sum  out  SUM_BITS  result for the requester flagged in rsp_valid
- busy  out  1  high while any request is outstanding

## Operation
- **Eligibility:** eligible[i] = req_valid[i] & ~outstanding[i]. Each requester has at most one request in flight.
- **Arbitration:**
  - Round-robin with priority pointer ptr (0..N_REQ-1).
  - The grant goes to the first eligible index scanning ptr, ptr+1, … modulo N_REQ.
  - req_ready is combinational from eligible and ptr.
  - Requesters must not make req_valid depend on req_ready.
- **Accept:** a request is accepted when req_valid[i] & req_ready[i] are high at a clock edge. On that edge:
  - outstanding[i] is set.
  - ptr becomes (i+1) mod N_REQ.
  - Operands and the one-hot tag enter pipeline stage 1.
  - With no grant, ptr holds.
- **Arithmetic:**
  - Both operands are extended to SUM_BITS: sign-extended if DTYPE=1, zero-extended if DTYPE=0.
  - The sum is exact; no overflow or quantisation is possible.
- **Pipeline:**
  - LATENCY stages, each holding a valid bit, a one-hot tag and the data; stages advance every cycle with no stall.
  - The final stage drives rsp_valid (tag gated by valid) and rsp_sum.
- **Response:**
  - In the cycle rsp_valid[i] is high, outstanding[i] clears at the following edge.
  - Requester i is therefore eligible again one cycle after its response, not in the response cycle.
- **busy:** |outstanding (registered).
- **Idle rsp_sum:** rsp_sum is don't-care when rsp_valid == 0; the bench must not check it then.
- **Reset, and reset mid-operation:** rst clears ptr to 0 and clears all outstanding and stage valid bits. In-flight results are discarded and no rsp_valid fires for them.
- **Reset values:**
  - rsp_valid = 0, busy = 0.
  - req_ready = 0 while rst is high.
  - rsp_sum = 0.

## Timing
- Request accepted at edge of cycle T → rsp_valid/rsp_sum valid during cycle T+LATENCY.
- Peak throughput: one grant per cycle across requesters.
- Per requester: one grant every LATENCY+1 cycles.
- A request held on req_valid while a lower-priority index is granted keeps its operands stable; operands are sampled only on accept.
- Same-cycle accept and response on different requesters are independent.
- Accept on a requester in its own response cycle cannot occur, because it is not eligible then.
- req_valid dropped before grant is legal; nothing is recorded.
- rst high for one cycle is sufficient. With rst asserted in cycle T, all outputs are at reset values from cycle T+1.

## Test plan
Defaults: N_REQ=4, DATA_BITS=8, DTYPE=1, LATENCY=2.

1. **Single request:** req 2 with a=8'h7F, b=8'h01 at cycle T → req_ready=4'b0100 at T; rsp_valid=4'b0100 and rsp_sum=9'h080 (+128) at T+2; busy high from T+1 through T+2.
2. **Sign handling:**
   - a=8'h80, b=8'h80 on req 0 → rsp_sum=9'h100 (-256).
   - With DTYPE=0, a=8'hFF, b=8'hFF → rsp_sum=9'h1FE (510).
3. **Full contention:** all four req_valid held high from reset release at T → grants at T..T+5 are 0,1,2,3,0,1; responses at T+2..T+7 are in the same order, each with the correct per-requester sum.
4. **Single hog:** only req 1 valid continuously from T → grants at T, T+3, T+6; rsp_valid[1] at T+2, T+5, T+8.
5. **Rotation:** ptr = 2 (after a grant to req 1), then req 0 and req 3 are valid together → grant to req 3; next cycle grant to req 0.
6. **Reset mid-flight:** grant req 0 at T, rst high during T+1 → no rsp_valid at T+2; busy=0 from T+2; the next request from req 0 is granted immediately and returns the correct sum.
